fmap_stream_reader: RTL and testbench

//  Feeder for the 6-channel 5x5 convolution stage (conv556). Reads a stored 6-channel
//  MAP_SIZE x MAP_SIZE feature map from a 1-cycle-latency SRAM in raster order and drives
//  the conv stage's en/rst/next0..next5 inputs. Flags the cycles where the conv output
//  (convValue) is a real window, and gives that window's output coordinates.

---
 rtl/fmap_stream_reader.sv | 196 +++++++++++++++++++
 tb/tb_fmap_stream_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_reader.sv
// Raster-order reader for a stored 6-channel feature map: streams SRAM words into the
// 6-channel conv stage and flags which conv outputs are real (non-wrapping) windows.
module fmap_stream_reader #(
  parameter int BIT_WIDTH  = 8,
  parameter int MAP_SIZE   = 14,
  parameter int KERNEL     = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [6*BIT_WIDTH-1:0] mem_data,
  output logic                   conv_en,
  output logic                   conv_clr,
  output logic [BIT_WIDTH-1:0]   next0,
  output logic [BIT_WIDTH-1:0]   next1,
  output logic [BIT_WIDTH-1:0]   next2,
  output logic [BIT_WIDTH-1:0]   next3,
  output logic [BIT_WIDTH-1:0]   next4,
  output logic [BIT_WIDTH-1:0]   next5,
  output logic                   out_valid,
  output logic [7:0]             out_row,
  output logic [7:0]             out_col,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned             NPIX      = MAP_SIZE * MAP_SIZE;
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [7:0]              MAP_LAST  = 8'(MAP_SIZE - 1);
  localparam logic [7:0]              K_LAST    = 8'(KERNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                   state_q;
  logic [ADDR_WIDTH-1:0]    rd_addr_q;
  logic                     inflight_q;
  logic                     dat_v_q, skid_v_q;
  logic [6*BIT_WIDTH-1:0]   dat_q, skid_q;
  logic                     dat_v_d, skid_v_d;
  logic [6*BIT_WIDTH-1:0]   dat_d, skid_d;
  logic [7:0]               prow_q, pcol_q;
  logic                     last_push_q;
  logic                     conv_clr_q, out_valid_q, busy_q, done_q;
  logic [7:0]               out_row_q, out_col_q;
  logic                     push_s, rd_s;
  logic [1:0]               stored_s;

  // Push/read decisions and the two-entry (data + skid) queue update
  always_comb begin
    push_s   = dat_v_q & ~hold;
    stored_s = 2'({1'b0, dat_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q} - {1'b0, push_s});
    rd_s     = (state_q == S_STREAM) & ~hold & (stored_s <= 2'd1);
    dat_v_d  = dat_v_q;
    dat_d    = dat_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (push_s) begin
      dat_v_d  = skid_v_q;
      dat_d    = skid_q;
      skid_v_d = 1'b0;
    end else begin
      dat_v_d  = dat_v_q;
    end
    // A returning word fills the oldest free slot so pushes stay in raster order
    if (inflight_q) begin
      if (!dat_v_d) begin
        dat_v_d = 1'b1;
        dat_d   = mem_data;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = mem_data;
      end
    end else begin
      skid_v_d = skid_v_d;
    end
  end

  // Sequencer, read/push counters, window flagging and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      dat_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      dat_q       <= '0;
      skid_q      <= '0;
      prow_q      <= 8'd0;
      pcol_q      <= 8'd0;
      last_push_q <= 1'b0;
      conv_clr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= 8'd0;
      out_col_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dat_v_q    <= dat_v_d;
      dat_q      <= dat_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      inflight_q <= rd_s;
      if (rd_s && (rd_addr_q != LAST_ADDR)) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      end
      if (push_s) begin
        out_valid_q <= (prow_q >= K_LAST) && (pcol_q >= K_LAST);
        if ((prow_q >= K_LAST) && (pcol_q >= K_LAST)) begin
          out_row_q <= prow_q - K_LAST;
          out_col_q <= pcol_q - K_LAST;
        end
        last_push_q <= (prow_q == MAP_LAST) && (pcol_q == MAP_LAST);
        if (pcol_q == MAP_LAST) begin
          pcol_q <= 8'd0;
          prow_q <= prow_q + 8'd1;
        end else begin
          pcol_q <= pcol_q + 8'd1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          conv_clr_q <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            state_q     <= S_CLEAR;
            conv_clr_q  <= 1'b1;
            busy_q      <= 1'b1;
            rd_addr_q   <= '0;
            prow_q      <= 8'd0;
            pcol_q      <= 8'd0;
            last_push_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q     <= S_STREAM;
          conv_clr_q  <= 1'b0;
          rd_addr_q   <= '0;
          prow_q      <= 8'd0;
          pcol_q      <= 8'd0;
          last_push_q <= 1'b0;
        end
        S_STREAM: begin
          if (rd_s && (rd_addr_q == LAST_ADDR)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_push_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          conv_clr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = rd_s;
  assign mem_addr  = rd_addr_q;
  assign conv_en   = push_s;
  assign conv_clr  = conv_clr_q;
  assign next0     = dat_q[0*BIT_WIDTH +: BIT_WIDTH];
  assign next1     = dat_q[1*BIT_WIDTH +: BIT_WIDTH];
  assign next2     = dat_q[2*BIT_WIDTH +: BIT_WIDTH];
  assign next3     = dat_q[3*BIT_WIDTH +: BIT_WIDTH];
  assign next4     = dat_q[4*BIT_WIDTH +: BIT_WIDTH];
  assign next5     = dat_q[5*BIT_WIDTH +: BIT_WIDTH];
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: nominal pass, hold stalls, ignored restart,
// mid-pass reset with rerun, and a MAP_SIZE=KERNEL=5 instance.
module tb_fmap_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start5 = 1'b0;
  logic        hold = 1'b0;
  logic        mem_rd, conv_en, conv_clr, out_valid, busy, done;
  logic [7:0]  mem_addr, out_row, out_col;
  logic [47:0] mem_data = 48'd0;
  logic [7:0]  next0, next1, next2, next3, next4, next5;
  logic        mem_rd5, conv_en5, conv_clr5, out_valid5, busy5, done5;
  logic [4:0]  mem_addr5;
  logic [7:0]  out_row5, out_col5;
  logic [47:0] mem_data5 = 48'd0;
  logic [7:0]  n50, n51, n52, n53, n54, n55;

  int cyc = 0, t0 = 0, rel;
  int checks = 0, fails = 0;
  int push_cnt, push_err, first_en, last_en, hold_err;
  int ov_cnt, ov_err, first_ov, last_ov, done_cnt, done_cyc, clr_cyc;
  int p5_cnt = 0, p5_err = 0, p5_last = 0, ov5_cnt = 0, ov5_cyc = 0, done5_cnt = 0;
  logic [7:0] ov5_row = 8'd0, ov5_col = 8'd0;
  logic completed;

  always #5 clk = ~clk;

  fmap_stream_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .conv_en(conv_en), .conv_clr(conv_clr),
    .next0(next0), .next1(next1), .next2(next2), .next3(next3), .next4(next4), .next5(next5),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  fmap_stream_reader #(.BIT_WIDTH(8), .MAP_SIZE(5), .KERNEL(5), .ADDR_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .hold(1'b0),
    .mem_rd(mem_rd5), .mem_addr(mem_addr5), .mem_data(mem_data5),
    .conv_en(conv_en5), .conv_clr(conv_clr5),
    .next0(n50), .next1(n51), .next2(n52), .next3(n53), .next4(n54), .next5(n55),
    .out_valid(out_valid5), .out_row(out_row5), .out_col(out_col5), .busy(busy5), .done(done5)
  );

  // SRAM models: every channel of word a holds a
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd)  mem_data  <= {6{mem_addr}};
    if (mem_rd5) mem_data5 <= {6{3'b000, mem_addr5}};
  end

  // Event monitor for the default-size DUT; raster-order push and window model
  always @(negedge clk) begin
    rel = cyc - t0;
    if (conv_en) begin
      if (next0 !== 8'(push_cnt) || next3 !== 8'(push_cnt) || next5 !== 8'(push_cnt)) push_err++;
      if (push_cnt == 0) first_en = rel;
      last_en = rel;
      push_cnt++;
    end
    if (hold && (conv_en || mem_rd)) hold_err++;
    if (out_valid) begin
      if (out_row !== 8'(ov_cnt / 10) || out_col !== 8'(ov_cnt % 10)) ov_err++;
      if (ov_cnt == 0) first_ov = rel;
      last_ov = rel;
      ov_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = rel;
    end
    if (conv_clr) clr_cyc = rel;
    if (conv_en5) begin
      if (n50 !== 8'(p5_cnt) || n55 !== 8'(p5_cnt)) p5_err++;
      p5_last = cyc;
      p5_cnt++;
    end
    if (out_valid5) begin
      ov5_cnt++;
      ov5_cyc = cyc;
      ov5_row = out_row5;
      ov5_col = out_col5;
    end
    if (done5) done5_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    push_cnt = 0; push_err = 0; first_en = -1; last_en = -1; hold_err = 0;
    ov_cnt = 0; ov_err = 0; first_ov = -1; last_ov = -1;
    done_cnt = 0; done_cyc = -1; clr_cyc = -1;
  endtask

  // One pass: start at cycle 0, optional hold pattern, re-start pulse, or one-cycle reset
  task automatic run_pass(input int hold_mode, input int restart_at, input int rst_at);
    clear_stats();
    completed = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    for (int k = 1; k < 600; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      hold  = (hold_mode != 0) && (done_cnt == 0) &&
              ((k >= 20 && k <= 22) || (k > 22 && (k % 7) == 0));
      rst   = (k != rst_at);
      if (k == rst_at) begin
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en_rd", 32'({conv_en, mem_rd, conv_clr, out_valid, done}), 32'd0);
        chk("rst_addr_data", 32'({mem_addr, next0, out_row, out_col}), 32'd0);
      end
      if (rst_at < 0 && done_cnt > 0 && k >= done_cyc + 2) begin
        completed = 1'b1;
        break;
      end
      if (rst_at >= 0 && k >= rst_at + 20) begin
        completed = 1'b1;
        break;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
    rst   = 1'b1;
    chk("pass_completed", 32'(completed), 32'd1);
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_clr_cyc"},   32'(clr_cyc),  32'd1);
    chk({tag, "_first_en"},  32'(first_en), 32'd4);
    chk({tag, "_last_en"},   32'(last_en),  32'd199);
    chk({tag, "_pushes"},    32'(push_cnt), 32'd196);
    chk({tag, "_push_err"},  32'(push_err), 32'd0);
    chk({tag, "_ov_cnt"},    32'(ov_cnt),   32'd100);
    chk({tag, "_ov_err"},    32'(ov_err),   32'd0);
    chk({tag, "_first_ov"},  32'(first_ov), 32'd65);
    chk({tag, "_last_ov"},   32'(last_ov),  32'd200);
    chk({tag, "_last_rc"},   32'({out_row, out_col}), 32'h0909);
    chk({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
    chk({tag, "_done_cyc"},  32'(done_cyc), 32'd201);
    chk({tag, "_idle_busy"}, 32'(busy),     32'd0);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, conv_en, mem_rd, conv_clr, out_valid}), 32'd0);
    chk("reset_regs", 32'({mem_addr, out_row, out_col, next0}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(0, -1, -1);
    check_nominal("s1");

    run_pass(1, -1, -1);
    chk("s2_pushes",   32'(push_cnt), 32'd196);
    chk("s2_push_err", 32'(push_err), 32'd0);
    chk("s2_ov_cnt",   32'(ov_cnt),   32'd100);
    chk("s2_ov_err",   32'(ov_err),   32'd0);
    chk("s2_hold_err", 32'(hold_err), 32'd0);
    chk("s2_done_cnt", 32'(done_cnt), 32'd1);

    run_pass(0, 50, -1);
    chk("s3_pushes",   32'(push_cnt), 32'd196);
    chk("s3_done_cnt", 32'(done_cnt), 32'd1);
    chk("s3_done_cyc", 32'(done_cyc), 32'd201);

    run_pass(0, -1, 100);
    chk("s4_no_done", 32'(done_cnt), 32'd0);
    chk("s4_idle",    32'({busy, conv_en, mem_rd}), 32'd0);
    run_pass(0, -1, -1);
    check_nominal("s4_rerun");

    @(posedge clk); #1;
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int k = 0; k < 100 && done5_cnt == 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("s5_pushes",   32'(p5_cnt),    32'd25);
    chk("s5_push_err", 32'(p5_err),    32'd0);
    chk("s5_ov_cnt",   32'(ov5_cnt),   32'd1);
    chk("s5_ov_rc",    32'({ov5_row, ov5_col}), 32'd0);
    chk("s5_ov_cyc",   32'(ov5_cyc - p5_last), 32'd1);
    chk("s5_done_cnt", 32'(done5_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
